distcalc_multi: RTL and testbench

Streaming, multi-mode vector distance engine; parametrised successor to the fixed-width Euclidean distance calculator. Accepts two unsigned integer vectors as a sequence of LANES-wide chunks over a valid/ready handshake and accumulates across chunks. Returns one of four distance metrics through an output valid/ready handshake. Sits between the vector buffer and the classifier/compare stage of the BDPU datapath.

---
 rtl/distcalc_pkg.sv | 24 ++
 rtl/isqrt_seq.sv | 75 +++++++
 rtl/distcalc_multi.sv | 191 +++++++++++++++++++
 tb/tb_distcalc_multi.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/distcalc_pkg.sv
// Shared definitions for the streaming vector distance engine:
// metric codes, FSM encodings and the accumulator width rule.
package distcalc_pkg;

  localparam logic [1:0] MODE_SQEUC = 2'd0;
  localparam logic [1:0] MODE_EUC   = 2'd1;
  localparam logic [1:0] MODE_MAN   = 2'd2;
  localparam logic [1:0] MODE_CHEB  = 2'd3;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_SQRT  = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // Width that holds a full squared-difference sum over lanes*maxchunks elements
  function automatic int unsigned acc_width(input int unsigned vw,
                                            input int unsigned lanes,
                                            input int unsigned maxchunks);
    return 2 * vw + $clog2(lanes * maxchunks);
  endfunction

endpackage

// File: rtl/isqrt_seq.sv
// Sequential digit-by-digit integer square root, one result bit per cycle.
// The first digit is resolved on the start edge; done pulses with root valid.
module isqrt_seq #(
  parameter int unsigned WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [WIDTH-1:0]         a,
  output logic                     busy,
  output logic                     done,
  output logic [(WIDTH+1)/2-1:0]   root
);

  localparam int unsigned RW   = (WIDTH + 1) / 2;
  localparam int unsigned PW   = 2 * RW;
  localparam int unsigned REMW = RW + 2;
  localparam int unsigned CW   = $clog2(RW + 1);

  logic [PW-1:0]   a_sh;
  logic [REMW-1:0] rem;
  logic [CW-1:0]   cnt;

  logic [PW-1:0]   a_ext;
  logic [1:0]      pair;
  logic [REMW-1:0] rem_src, rem_sh, trial, rem_step;
  logic [RW-1:0]   root_src, root_step;

  // One restoring step: bring down two bits, try subtracting 4*root+1
  always_comb begin
    a_ext     = PW'(a);
    rem_src   = start ? '0 : rem;
    root_src  = start ? '0 : root;
    pair      = start ? a_ext[PW-1 -: 2] : a_sh[PW-1 -: 2];
    rem_sh    = {rem_src[REMW-3:0], pair};
    trial     = {root_src, 2'b01};
    rem_step  = rem_sh;
    root_step = {root_src[RW-2:0], 1'b0};
    if (rem_sh >= trial) begin
      rem_step  = rem_sh - trial;
      root_step = {root_src[RW-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh <= '0;
      rem  <= '0;
      root <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem  <= rem_step;
        root <= root_step;
        a_sh <= {a_ext[PW-3:0], 2'b00};
        cnt  <= CW'(RW - 1);
        busy <= (RW > 1);
        done <= (RW == 1);
      end else if (busy) begin
        rem  <= rem_step;
        root <= root_step;
        a_sh <= {a_sh[PW-3:0], 2'b00};
        cnt  <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/distcalc_multi.sv
// Streaming multi-metric distance engine: accumulates LANES-wide chunks of two
// vectors and returns squared Euclidean, Euclidean, Manhattan or Chebyshev distance.
module distcalc_multi
  import distcalc_pkg::*;
#(
  parameter int unsigned VARWIDTH  = 16,
  parameter int unsigned LANES     = 8,
  parameter int unsigned MAXCHUNKS = 16,
  localparam int unsigned ACCWIDTH = acc_width(VARWIDTH, LANES, MAXCHUNKS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic [LANES-1:0]          in_mask,
  input  logic [1:0]                mode,
  input  logic [VARWIDTH*LANES-1:0] invec0,
  input  logic [VARWIDTH*LANES-1:0] invec1,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACCWIDTH-1:0]       outval,
  output logic                      out_err
);

  localparam int unsigned TW   = 2 * VARWIDTH;
  localparam int unsigned CNTW = $clog2(MAXCHUNKS + 2);
  localparam int unsigned RW   = (ACCWIDTH + 1) / 2;

  state_e state, state_next;

  logic [ACCWIDTH-1:0] acc, cr;
  logic                cr_valid, err;
  logic [CNTW-1:0]     cnt;
  logic [1:0]          mode_q;

  logic                accept_c, clr_c, sq_start_c;
  logic [1:0]          mode_eff;
  logic                square_c;
  logic [TW-1:0]       term [LANES];
  logic [ACCWIDTH-1:0] chunk_sum, cr_next, acc_fold;
  logic [TW-1:0]       chunk_max;
  logic [ACCWIDTH:0]   sum_c;
  logic                sat_c;

  logic                sq_busy, sq_done;
  logic [RW-1:0]       sq_root;

  logic                in_ready_next, out_valid_next, out_err_next;
  logic [ACCWIDTH-1:0] outval_next;

  assign accept_c = in_valid && in_ready;
  assign clr_c    = (state == ST_OUT) && out_ready;
  // Mode is taken live on the first chunk, latched thereafter
  assign mode_eff = (cnt == '0) ? mode : mode_q;
  assign square_c = (mode_eff == MODE_SQEUC) || (mode_eff == MODE_EUC);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [VARWIDTH-1:0] a_l, b_l, d_l;
    assign a_l     = invec0[i*VARWIDTH +: VARWIDTH];
    assign b_l     = invec1[i*VARWIDTH +: VARWIDTH];
    assign d_l     = (a_l >= b_l) ? (a_l - b_l) : (b_l - a_l);
    assign term[i] = !in_mask[i] ? '0 :
                     square_c    ? (TW'(d_l) * TW'(d_l)) : TW'(d_l);
  end

  // Chunk reduction: sum for additive metrics, max for Chebyshev
  always_comb begin
    chunk_sum = '0;
    chunk_max = '0;
    for (int i = 0; i < LANES; i++) begin
      chunk_sum = chunk_sum + ACCWIDTH'(term[i]);
      if (term[i] > chunk_max) chunk_max = term[i];
    end
    cr_next = (mode_eff == MODE_CHEB) ? ACCWIDTH'(chunk_max) : chunk_sum;
  end

  // Fold of the registered chunk into the accumulator, saturating
  always_comb begin
    sum_c    = {1'b0, acc} + {1'b0, cr};
    sat_c    = (mode_q != MODE_CHEB) && sum_c[ACCWIDTH];
    acc_fold = sum_c[ACCWIDTH-1:0];
    if (mode_q == MODE_CHEB) acc_fold = (cr > acc) ? cr : acc;
    else if (sat_c)          acc_fold = '1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      cr       <= '0;
      cr_valid <= 1'b0;
      cnt      <= '0;
      err      <= 1'b0;
      mode_q   <= MODE_SQEUC;
    end else if (clr_c) begin
      acc      <= '0;
      cr_valid <= 1'b0;
      cnt      <= '0;
      err      <= 1'b0;
    end else begin
      if (cr_valid) begin
        acc <= acc_fold;
        if (sat_c) err <= 1'b1;
      end
      cr_valid <= accept_c;
      if (accept_c) begin
        cr <= cr_next;
        if (cnt == '0) mode_q <= mode;
        if (cnt != CNTW'(MAXCHUNKS + 1)) cnt <= cnt + CNTW'(1);
        if (cnt == CNTW'(MAXCHUNKS)) err <= 1'b1;
      end
    end
  end

  isqrt_seq #(.WIDTH(ACCWIDTH)) u_isqrt (
    .clk   (clk),
    .rst   (rst),
    .start (sq_start_c),
    .a     (acc),
    .busy  (sq_busy),
    .done  (sq_done),
    .root  (sq_root)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ACC;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      outval    <= '0;
      out_err   <= 1'b0;
    end else begin
      state     <= state_next;
      in_ready  <= in_ready_next;
      out_valid <= out_valid_next;
      outval    <= outval_next;
      out_err   <= out_err_next;
    end
  end

  // FLUSH waits until the final chunk has been folded before leaving
  always_comb begin
    state_next     = state;
    in_ready_next  = 1'b0;
    out_valid_next = 1'b0;
    outval_next    = outval;
    out_err_next   = out_err;
    sq_start_c     = 1'b0;
    case (state)
      ST_ACC: begin
        in_ready_next = 1'b1;
        if (accept_c && in_last) begin
          state_next    = ST_FLUSH;
          in_ready_next = 1'b0;
        end
      end
      ST_FLUSH: begin
        if (!cr_valid) begin
          if (mode_q == MODE_EUC) begin
            state_next = ST_SQRT;
            sq_start_c = 1'b1;
          end else begin
            state_next     = ST_OUT;
            out_valid_next = 1'b1;
            outval_next    = acc;
            out_err_next   = err;
          end
        end
      end
      ST_SQRT: begin
        if (sq_done && !sq_busy) begin
          state_next     = ST_OUT;
          out_valid_next = 1'b1;
          outval_next    = ACCWIDTH'(sq_root);
          out_err_next   = err;
        end
      end
      ST_OUT: begin
        out_valid_next = 1'b1;
        if (out_ready) begin
          state_next     = ST_ACC;
          in_ready_next  = 1'b1;
          out_valid_next = 1'b0;
          out_err_next   = 1'b0;
        end
      end
      default: state_next = ST_ACC;
    endcase
  end

endmodule

// File: tb/tb_distcalc_multi.sv
// Bench for distcalc_multi: directed vector table, reset/backpressure sequences,
// and random vectors checked against an arithmetic reference model.
module tb_distcalc_multi;

  localparam int unsigned VW  = 16;
  localparam int unsigned LN  = 4;
  localparam int unsigned MC  = 4;
  localparam int unsigned AW  = 36;
  localparam longint      MAXV = (longint'(1) << AW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_last, out_valid, out_ready, out_err;
  logic [LN-1:0] in_mask;
  logic [1:0]    mode;
  logic [VW*LN-1:0] invec0, invec1;
  logic [AW-1:0] outval;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  distcalc_multi #(.VARWIDTH(VW), .LANES(LN), .MAXCHUNKS(MC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_mask(in_mask), .mode(mode),
    .invec0(invec0), .invec1(invec1), .out_valid(out_valid),
    .out_ready(out_ready), .outval(outval), .out_err(out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Current vector under test
  logic [63:0]   va [8];
  logic [63:0]   vb [8];
  logic [3:0]    vm [8];
  logic [1:0]    vmode [8];
  int            vn;

  typedef struct {
    logic [1:0] mode0, mode_rest;
    int         n;
    logic [5:0][63:0] a, b;
    logic [5:0][3:0]  m;
    longint     ev;
    bit         ee;
    int         hold;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] pk(input int l0, input int l1, input int l2, input int l3);
    return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
  endfunction

  function automatic longint isqrt_ref(input longint x);
    longint r = 0;
    for (int b = 17; b >= 0; b--) begin
      longint t = r + (longint'(1) << b);
      if (t * t <= x) r = t;
    end
    return r;
  endfunction

  // Whole-vector reference: mode from the first chunk, saturating sum or running max
  function automatic void model(output longint ev, output bit ee);
    longint acc = 0;
    logic [1:0] m = vmode[0];
    ee = 1'b0;
    for (int c = 0; c < vn; c++) begin
      longint cr = 0;
      for (int l = 0; l < LN; l++) begin
        longint av = longint'(va[c][l*16 +: 16]);
        longint bv = longint'(vb[c][l*16 +: 16]);
        longint d = (av > bv) ? av - bv : bv - av;
        longint t = (m <= 2'd1) ? d * d : d;
        if (vm[c][l]) cr = (m == 2'd3) ? ((t > cr) ? t : cr) : cr + t;
      end
      if (m == 2'd3) acc = (cr > acc) ? cr : acc;
      else begin
        acc = acc + cr;
        if (acc > MAXV) begin acc = MAXV; ee = 1'b1; end
      end
      if (c >= int'(MC)) ee = 1'b1;
    end
    if (m == 2'd1) acc = isqrt_ref(acc);
    ev = acc;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_tbl(input int k);
    vn = tbl[k].n;
    for (int c = 0; c < vn; c++) begin
      va[c] = tbl[k].a[c];
      vb[c] = tbl[k].b[c];
      vm[c] = tbl[k].m[c];
      vmode[c] = (c == 0) ? tbl[k].mode0 : tbl[k].mode_rest;
    end
  endtask

  task automatic drive_chunk(input int c);
    in_valid = 1'b1;
    invec0   = va[c];
    invec1   = vb[c];
    in_mask  = vm[c];
    mode     = vmode[c];
    in_last  = (c == vn - 1);
  endtask

  // Stream the vector, check latency/result, optional backpressure, then release
  task automatic run_vec(input string nm, input longint ev, input bit ee,
                         input int hold, input bit gaps, input bit rnd_ordy);
    int acc_cyc = 0;
    int guard;
    int lat_exp = (vmode[0] == 2'd1) ? 2 + (AW + 1) / 2 : 2;
    for (int c = 0; c < vn; c++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        tick();
      end
      out_ready = rnd_ordy ? 1'($urandom_range(0, 1)) : 1'b0;
      drive_chunk(c);
      guard = 0;
      while (!in_ready && guard < 50) begin tick(); guard++; end
      chk({nm, "_in_ready_wait"}, in_ready, 1);
      tick();
      acc_cyc = cyc;
      chk({nm, "_in_ready_after_chunk"}, in_ready, (c == vn - 1) ? 0 : 1);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    invec0    = {$urandom, $urandom};
    guard = 0;
    while (!out_valid && guard < 60) begin tick(); guard++; end
    chk({nm, "_out_valid"}, out_valid, 1);
    chk({nm, "_latency"}, cyc - acc_cyc, lat_exp);
    chk({nm, "_outval"}, outval, ev);
    chk({nm, "_out_err"}, out_err, ee);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_last  = 1'b1;
      invec0   = {$urandom, $urandom};
      tick();
      chk({nm, "_hold_outval"}, outval, ev);
      chk({nm, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    chk({nm, "_release_in_ready"}, in_ready, 1);
    chk({nm, "_release_out_valid"}, out_valid, 0);
    chk({nm, "_release_out_err"}, out_err, 0);
  endtask

  initial begin
    longint ev;
    bit ee;
    bit partial;

    tbl[0] = '{mode0: 2'd0, mode_rest: 2'd0, n: 1, a: '0, b: '0, m: '0, ev: 25, ee: 0, hold: 0};
    tbl[0].a[0] = pk(3, 4, 0, 0); tbl[0].m[0] = 4'hF;
    tbl[1] = tbl[0]; tbl[1].mode0 = 2'd1; tbl[1].ev = 5;
    tbl[2] = '{mode0: 2'd2, mode_rest: 2'd2, n: 2, a: '0, b: '0, m: '0, ev: 13, ee: 0, hold: 0};
    tbl[2].a[0] = pk(10, 0, 5, 7); tbl[2].b[0] = pk(3, 2, 5, 9); tbl[2].m[0] = 4'hF;
    tbl[2].a[1] = pk(1, 1, 1, 1);  tbl[2].m[1] = 4'b0011;
    tbl[3] = '{mode0: 2'd3, mode_rest: 2'd0, n: 2, a: '0, b: '0, m: '0, ev: 65535, ee: 0, hold: 0};
    tbl[3].a[0] = pk(1, 65535, 2, 0); tbl[3].m[0] = 4'hF;
    tbl[3].a[1] = pk(9, 9, 9, 9);     tbl[3].m[1] = 4'hF;
    tbl[4] = '{mode0: 2'd0, mode_rest: 2'd0, n: 5, a: '0, b: '0, m: '0, ev: MAXV, ee: 1, hold: 10};
    for (int c = 0; c < 5; c++) begin
      tbl[4].a[c] = pk(65535, 65535, 65535, 65535);
      tbl[4].m[c] = 4'hF;
    end

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_mask = '0; mode = '0;
    invec0 = '0; invec1 = '0; out_ready = 1'b0;
    repeat (3) tick();
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_outval", outval, 0);
    chk("reset_out_err", out_err, 0);
    rst = 1'b0;
    tick();
    chk("release_in_ready", in_ready, 1);

    for (int k = 0; k < 5; k++) begin
      load_tbl(k);
      run_vec($sformatf("tbl%0d", k), tbl[k].ev, tbl[k].ee, tbl[k].hold, 1'b0, 1'b0);
    end

    // Reset during the square-root phase drops the vector entirely
    load_tbl(1);
    drive_chunk(0);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (8) tick();
    chk("sqrt_phase_out_valid", out_valid, 0);
    rst = 1'b1;
    tick();
    chk("rst_sqrt_out_valid", out_valid, 0);
    chk("rst_sqrt_outval", outval, 0);
    chk("rst_sqrt_in_ready", in_ready, 0);
    rst = 1'b0;
    tick();
    chk("rst_sqrt_in_ready_after", in_ready, 1);
    partial = 1'b0;
    repeat (25) begin
      tick();
      if (out_valid) partial = 1'b1;
    end
    chk("rst_sqrt_no_partial", partial, 0);
    load_tbl(2);
    run_vec("post_rst", 13, 1'b0, 0, 1'b0, 1'b0);

    for (int r = 0; r < 40; r++) begin
      vn = $urandom_range(1, 6);
      for (int c = 0; c < vn; c++) begin
        for (int l = 0; l < LN; l++) begin
          bit ext = ($urandom_range(0, 3) == 0);
          va[c][l*16 +: 16] = ext ? 16'hFFFF : 16'($urandom);
          vb[c][l*16 +: 16] = ext ? 16'h0000 : 16'($urandom);
        end
        vm[c]    = 4'($urandom);
        vmode[c] = 2'($urandom);
      end
      model(ev, ee);
      run_vec($sformatf("rnd%0d", r), ev, ee, $urandom_range(0, 3), 1'b1, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
